keyboard_uart_tx_bridge: RTL and testbench
==========================================

# keyboard_uart_tx_bridge

Parametrised byte-stream-to-UART bridge for the keyboard path: accepts translated keyboard bytes on a valid/ready port, buffers them in an internal FIFO, and serialises them on a UART TX line. It replaces the fixed FIFO-plus-consumer-plus-transmitter chain with one configurable block. It adds configurable FIFO depth, baud, stop bits, CTS hardware flow control, overflow accounting and optional parity.

## Interface
- ClkFrequency, 100_000_000: clock frequency in Hz.
- Baud, 115_200: line rate. BitCycles = ClkFrequency / Baud, truncated, must be ≥ 4.
- FifoDepth, 16: FIFO entries, a power of two ≥ 2.
- StopBits, 1: stop bits per frame, 1 or 2.

- clk  in  1  system clock; every register is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- inValid  in  1  producer has a byte on inData.
- inData  in  8  byte from the keyboard translator.
- inReady  out  1  equals !full. A byte is accepted when inValid && inReady.
- ctsN  in  1  asynchronous active-low clear-to-send from the host, passed through a 2-flop synchroniser.
- ovfClear  in  1  clears overflow and dropCount.
- uartTx  out  1  serial output; idles high.
- uartBusy  out  1  high while a frame is on the line.
- fifoLevel  out  $clog2(FifoDepth)+1  current entry count.
- overflow  out  1  sticky flag; set when a byte is offered while the FIFO is full.
- dropCount  out  8  saturating count of dropped bytes.

## Operation
- Reset values: uartTx=1, uartBusy=0, inReady=1, fifoLevel=0, overflow=0, dropCount=0. FSM in IDLE; synchroniser flops hold 1, i.e. not clear.
- FIFO: circular buffer with registered read/write pointers and a count.
  - Push on inValid && !full.
  - Pop is issued only by the FSM, in IDLE.
  - A push is blocked while full even if a pop occurs in the same cycle.
  - Pointers wrap modulo FifoDepth.
- Drop: inValid && full sets overflow and increments dropCount, which saturates at 255. The byte is discarded and the producer is not stalled by this block.
- ovfClear clears overflow and dropCount. If a drop occurs in the same cycle, the drop wins: overflow=1 and dropCount=1.
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: if !empty and the synchronised ctsN is 0, pop the head into a shift register, clear the bit counter and baud counter, and go to START.
  - START: uartTx=0 for BitCycles cycles.
  - DATA: 8 bits, LSB first, each held BitCycles cycles.
  - PARITY: present only with the macro enabled (see Configuration); one bit time.
  - STOP: uartTx=1 for StopBits×BitCycles cycles, then go to IDLE.
- uartBusy=1 in every state except IDLE.
- CTS is sampled only in IDLE. A frame in progress always completes after ctsN rises; the next frame is held while ctsN is high.
- Baud counter: counts 0..BitCycles-1 and restarts at every frame start. There is no free-running phase.

## Timing
- Byte accepted at edge k on an empty FIFO with CTS already asserted → uartTx low from edge k+1. The start bit then lasts exactly BitCycles cycles.
- Back-to-back frames: the FSM returns to IDLE on the last stop-bit cycle. The next START begins at the following edge, so there are 0 extra idle cycles between frames.
- Frame length: (10 + StopBits − 1 + P) × BitCycles cycles, with P = 1 when parity is enabled and 0 otherwise.
- ctsN falling → eligible for pop 2 edges later, due to the synchroniser.
- fifoLevel and inReady update on the edge following push or pop.
- Reset mid-frame: at the next edge uartTx=1, the FIFO is emptied and all counters are cleared. The partial frame is abandoned.

## Configuration
- KBD_UART_PARITY_EN defined: a PARITY state follows DATA and transmits even parity (XOR of the 8 data bits).
- Not defined: no PARITY state; frames are 8N1 or 8N2.

## Test plan
Unless stated otherwise, runs use ClkFrequency=1_000_000 and Baud=100_000, giving BitCycles=10.
- Single byte 0x1C, ctsN=0, StopBits=1 → uartTx low 1 cycle after accept, then bits 0,0,1,1,1,0,0,0 at 10 cycles each, then high. uartBusy high for exactly 100 cycles.
- Burst of 17 bytes 0x00..0x10 in consecutive cycles, FifoDepth=16, ctsN=1 → inReady=0 after 16 pushes; 17th byte dropped; overflow=1, dropCount=1. Then ctsN=0 → 16 frames sent back-to-back with no gaps.
- ctsN raised mid-frame of the first of 2 queued bytes → first frame completes; second is held until ctsN=0 plus 2 cycles.
- 300 bytes offered while full → dropCount saturates at 255. ovfClear pulsed with no drop → overflow=0, dropCount=0.
- rst asserted in the 5th data bit → next edge uartTx=1, fifoLevel=0, uartBusy=0. A fresh byte afterwards is sent correctly.
- KBD_UART_PARITY_EN with 0x07, then 0x03 → parity bits 1, then 0; frame is 110 cycles. StopBits=2 → frame is 120 cycles.

Source files
------------

// File: rtl/keyboard_uart_tx_bridge.sv
// Keyboard byte FIFO feeding a CTS-gated UART transmitter; tx starts 1 cycle after accept, full FIFO drops (counted) instead of stalling.
// Optional even parity bit after the data bits when KBD_UART_PARITY_EN is defined.
module keyboard_uart_tx_bridge #(
  parameter int ClkFrequency = 100_000_000,
  parameter int Baud         = 115_200,
  parameter int FifoDepth    = 16,
  parameter int StopBits     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  input  logic [7:0]                 in_data_i,
  output logic                       in_ready_o,
  input  logic                       cts_n_i,
  input  logic                       ovf_clear_i,
  output logic                       uart_tx_o,
  output logic                       uart_busy_o,
  output logic [$clog2(FifoDepth):0] fifo_level_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_count_o
);

  localparam int BitCycles  = ClkFrequency / Baud;
  localparam int StopCycles = StopBits * BitCycles;
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int LvlW       = PtrW + 1;
  localparam int CntW       = $clog2(StopCycles + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(StopCycles - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic            cts_s1_q, cts_s2_q;
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_q, drop_d;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            full, empty, push, pop, drop, can_start, tx_bit;

  assign full      = (count_q == LvlW'(FifoDepth));
  assign empty     = (count_q == '0);
  assign push      = in_valid_i && !full;
  assign drop      = in_valid_i && full;
  assign can_start = !empty && !cts_s2_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + LvlW'(1);
    else if (pop && !push) count_d = count_q - LvlW'(1);
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (ovf_clear_i)          drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (ovf_clear_i) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    tx_bit  = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_bit = data_q[bit_q];
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
`ifdef KBD_UART_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef KBD_UART_PARITY_EN
      PARITY: begin
        tx_bit = ^data_q;
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // The last stop cycle makes the idle decision itself so queued frames run gap-free.
        if (cnt_q == StopLast) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (can_start) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cts_s1_q   <= 1'b1;
      cts_s2_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
    end else begin
      cts_s1_q   <= cts_n_i;
      cts_s2_q   <= cts_s1_q;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
    end
  end

  assign in_ready_o   = !full;
  assign uart_tx_o    = tx_bit;
  assign uart_busy_o  = (state_q != IDLE);
  assign fifo_level_o = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_keyboard_uart_tx_bridge.sv
// Directed bench for keyboard_uart_tx_bridge: a line monitor decodes frames and checks them against a byte scoreboard.
module tb_keyboard_uart_tx_bridge;
`ifdef KBD_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BC     = 10;
  localparam int FRAME0 = (10 + 1 - 1 + P) * BC;
  localparam int FRAME1 = (10 + 2 - 1 + P) * BC;

  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 1'b0, cts0 = 1'b1, clr0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic rdy0, tx0, busy0, ovf0;
  logic [4:0] lvl0;
  logic [7:0] drop0;
  logic v1 = 1'b0, cts1 = 1'b0, clr1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic rdy1, tx1, busy1, ovf1;
  logic [4:0] lvl1;
  logic [7:0] drop1;

  int tests = 0, fails = 0, cyc = 0, frames_rx = 0;
  bit mon_en = 1'b1;
  logic [7:0] sb[$];
  int start_q[$];
  logic [7:0] mon_b;

  keyboard_uart_tx_bridge #(.ClkFrequency(1_000_000), .Baud(100_000), .FifoDepth(16), .StopBits(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v0), .in_data_i(d0), .in_ready_o(rdy0), .cts_n_i(cts0),
    .ovf_clear_i(clr0), .uart_tx_o(tx0), .uart_busy_o(busy0), .fifo_level_o(lvl0),
    .overflow_o(ovf0), .drop_count_o(drop0));

  keyboard_uart_tx_bridge #(.ClkFrequency(1_000_000), .Baud(100_000), .FifoDepth(16), .StopBits(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_data_i(d1), .in_ready_o(rdy1), .cts_n_i(cts1),
    .ovf_clear_i(clr1), .uart_tx_o(tx1), .uart_busy_o(busy1), .fifo_level_o(lvl1),
    .overflow_o(ovf1), .drop_count_o(drop1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] d, input bit expect_tx);
    v0 = 1'b1;
    d0 = d;
    if (expect_tx) sb.push_back(d);
    @(posedge clk); #1;
    v0 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy0 && n < budget) begin @(posedge clk); n++; end
    #1;
    chk("idle_reached", busy0, 1'b0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_rx < target && n < budget) begin @(posedge clk); n++; end
    #1;
    chk("frames_done", frames_rx, target);
  endtask

  // Line monitor: detects a start bit, samples each bit near its centre, pops the scoreboard.
  always begin
    @(negedge clk);
    if (mon_en && tx0 === 1'b0) begin
      start_q.push_back(cyc);
      repeat (4) @(negedge clk);
      chk("start_bit", tx0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (BC) @(negedge clk);
        mon_b[i] = tx0;
      end
`ifdef KBD_UART_PARITY_EN
      repeat (BC) @(negedge clk);
      chk("parity_bit", tx0, ^mon_b);
`endif
      repeat (BC) @(negedge clk);
      chk("stop_bit", tx0, 1'b1);
      chk("frame_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) chk("frame_data", mon_b, sb.pop_front());
      frames_rx++;
    end
  end

  initial begin
    int n, target;
    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_level", lvl0, 0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_drop", drop0, 0);
    rst = 1'b0;

    // Single byte 0x1C: start 1 cycle after accept, busy for one frame
    cts0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    target = frames_rx + 1;
    v0 = 1'b1; d0 = 8'h1C; sb.push_back(8'h1C);
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("accept_tx_idle", tx0, 1'b1);
    chk("level_after_push", lvl0, 1);
    @(posedge clk); #1;
    chk("start_latency_tx", tx0, 1'b0);
    chk("start_latency_busy", busy0, 1'b1);
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (!busy0) break;
      n++;
    end
    chk("busy_cycles_sb1", n, FRAME0);
    wait_frames(target, 50);

    // Burst of 17 with CTS held off: 16 queued, 1 dropped, then gap-free drain
    cts0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      push0(8'(i), i < 16);
      if (i == 14) chk("ready_before_full", rdy0, 1'b1);
      if (i == 15) begin
        chk("ready_when_full", rdy0, 1'b0);
        chk("level_full", lvl0, 16);
      end
    end
    chk("burst_ovf", ovf0, 1'b1);
    chk("burst_drop", drop0, 1);
    chk("burst_level", lvl0, 16);
    start_q.delete();
    target = frames_rx + 16;
    cts0 = 1'b0;
    wait_frames(target, 16 * FRAME0 + 200);
    chk("burst_starts", start_q.size(), 16);
    for (int k = 1; k < start_q.size(); k++) chk("burst_gap", start_q[k] - start_q[k-1], FRAME0);
    clr0 = 1'b1; @(posedge clk); #1; clr0 = 1'b0;
    chk("clear_ovf", ovf0, 1'b0);
    chk("clear_drop", drop0, 0);

    // CTS raised mid-frame: current frame completes, next one held
    wait_idle(200);
    target = frames_rx + 2;
    v0 = 1'b1; d0 = 8'hA5; sb.push_back(8'hA5);
    @(posedge clk); #1;
    d0 = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (30) @(posedge clk); #1;
    cts0 = 1'b1;
    wait_idle(200);
    chk("cts_first_done", frames_rx, target - 1);
    chk("cts_second_queued", lvl0, 1);
    repeat (50) @(posedge clk); #1;
    chk("cts_held", busy0, 1'b0);
    cts0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cts_sync_delay", busy0, 1'b0);
    @(posedge clk); #1;
    chk("cts_release_busy", busy0, 1'b1);
    chk("cts_release_tx", tx0, 1'b0);
    wait_frames(target, 2 * FRAME0 + 50);

    // Drop counter saturation and clear interactions
    wait_idle(200);
    cts0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) push0(8'h40 + 8'(i), 1'b1);
    v0 = 1'b1; d0 = 8'hEE;
    repeat (300) @(posedge clk); #1;
    v0 = 1'b0;
    chk("sat_drop", drop0, 255);
    chk("sat_ovf", ovf0, 1'b1);
    chk("sat_level", lvl0, 16);
    clr0 = 1'b1; @(posedge clk); #1; clr0 = 1'b0;
    chk("sat_clear_ovf", ovf0, 1'b0);
    chk("sat_clear_drop", drop0, 0);
    v0 = 1'b1; clr0 = 1'b1; @(posedge clk); #1; v0 = 1'b0; clr0 = 1'b0;
    chk("drop_wins_ovf", ovf0, 1'b1);
    chk("drop_wins_cnt", drop0, 1);
    clr0 = 1'b1; @(posedge clk); #1; clr0 = 1'b0;
    chk("reclear_drop", drop0, 0);
    target = frames_rx + 16;
    cts0 = 1'b0;
    wait_frames(target, 16 * FRAME0 + 200);

    // Reset during the 5th data bit abandons the frame and empties the FIFO
    wait_idle(200);
    mon_en = 1'b0;
    v0 = 1'b1; d0 = 8'h5A;
    @(posedge clk); #1;
    d0 = 8'h66;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (53) @(posedge clk); #1;
    chk("pre_rst_busy", busy0, 1'b1);
    chk("pre_rst_level", lvl0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_tx", tx0, 1'b1);
    chk("mid_rst_level", lvl0, 0);
    chk("mid_rst_busy", busy0, 1'b0);
    repeat (5) @(posedge clk); #1;
    mon_en = 1'b1;
    target = frames_rx + 1;
    push0(8'h81, 1'b1);
    wait_frames(target, FRAME0 + 50);

    // Two stop bits: frame length on the second instance
    wait_idle(200);
    v1 = 1'b1; d1 = 8'h07;
    @(posedge clk); #1;
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("sb2_start_tx", tx1, 1'b0);
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (!busy1) break;
      n++;
    end
    chk("busy_cycles_sb2", n, FRAME1);

    repeat (20) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
